// File: rtl/hazard_scoreboard.sv
// RAW hazard unit for the ID stage: tracks in-flight register writes in a shift scoreboard.
// Optional stall/freeze statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard #(
    parameter int REG_AW      = 4,
    parameter int STAGES      = 2,
    parameter int LOAD_SHADOW = 1,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              forward_en,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_use_src1,
    input  logic              id_use_src2,
    input  logic              id_wb_en,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_mem_r_en,
    input  logic              flush,
    input  logic              mem_busy,
    output logic              hazard,
    output logic              freeze,
    output logic [STAGES-1:0] sb_valid,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  freeze_cycles
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ld;
    logic [REG_AW-1:0] dest [STAGES];
    logic              raw;

    // With forwarding only a load still inside the shadow window blocks the reader.
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (v[i] && ((id_use_src1 && (id_src1 == dest[i])) ||
                         (id_use_src2 && (id_src2 == dest[i])))) begin
                if (!forward_en) begin
                    raw = 1'b1;
                end else if (ld[i] && (i < LOAD_SHADOW)) begin
                    raw = 1'b1;
                end
            end
        end
    end

    assign hazard   = id_valid && !flush && raw;
    assign freeze   = mem_busy;
    assign sb_valid = v;

    always_ff @(posedge clk) begin
        if (rst) begin
            v  <= '0;
            ld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dest[i] <= '0;
            end
        end else if (!mem_busy) begin
            for (int i = 1; i < STAGES; i++) begin
                v[i]    <= v[i-1];
                ld[i]   <= ld[i-1];
                dest[i] <= dest[i-1];
            end
            v[0]    <= id_valid && !flush && !hazard && id_wb_en;
            ld[0]   <= id_mem_r_en;
            dest[0] <= id_dest;
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] freeze_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            freeze_q <= '0;
        end else begin
            if (hazard && !mem_busy && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (mem_busy && (freeze_q != '1)) begin
                freeze_q <= freeze_q + CNT_ONE;
            end
        end
    end

    assign stall_cycles  = stall_q;
    assign freeze_cycles = freeze_q;
`else
    assign stall_cycles  = '0;
    assign freeze_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (2/1 and 3/2 stage configs) checked every cycle
// against an in-flight writer list model, plus directed stall-count scenarios.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        forward_en = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_src1 = '0;
    logic [3:0]  id_src2 = '0;
    logic        id_use_src1 = 1'b0;
    logic        id_use_src2 = 1'b0;
    logic        id_wb_en = 1'b0;
    logic [3:0]  id_dest = '0;
    logic        id_mem_r_en = 1'b0;
    logic        flush = 1'b0;
    logic        mem_busy = 1'b0;

    logic        hazard_a, hazard_b, freeze_a, freeze_b;
    logic [1:0]  sb_a;
    logic [2:0]  sb_b;
    logic [31:0] stall_a, stall_b, frz_a, frz_b;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(4), .STAGES(2), .LOAD_SHADOW(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_r_en(id_mem_r_en), .flush(flush),
        .mem_busy(mem_busy), .hazard(hazard_a), .freeze(freeze_a), .sb_valid(sb_a),
        .stall_cycles(stall_a), .freeze_cycles(frz_a));

    hazard_scoreboard #(.REG_AW(4), .STAGES(3), .LOAD_SHADOW(2), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_r_en(id_mem_r_en), .flush(flush),
        .mem_busy(mem_busy), .hazard(hazard_b), .freeze(freeze_b), .sb_valid(sb_b),
        .stall_cycles(stall_b), .freeze_cycles(frz_b));

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted writer is stamped with the advance count at issue; its age
    // in advances gives its pipeline position, and it retires once it passes the last stage.
    typedef struct {
        int         t;
        logic [3:0] dest;
        logic       ld;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    int  adv[2]    = '{0, 0};
    int  st_m[2]   = '{0, 0};
    int  fz_m[2]   = '{0, 0};
    int  stages[2] = '{2, 3};
    int  shadow[2] = '{1, 2};

    function automatic logic model_hz(int k);
        wr_t  q[$];
        int   age;
        logic raw = 1'b0;
        if (k == 0) q = q0; else q = q1;
        foreach (q[j]) begin
            age = adv[k] - q[j].t - 1;
            if (((id_use_src1 && id_src1 == q[j].dest) || (id_use_src2 && id_src2 == q[j].dest)) &&
                (!forward_en || (q[j].ld && age < shadow[k])))
                raw = 1'b1;
        end
        return id_valid && !flush && raw;
    endfunction

    function automatic logic [2:0] model_sb(int k);
        wr_t        q[$];
        logic [2:0] sb = '0;
        if (k == 0) q = q0; else q = q1;
        foreach (q[j]) sb[adv[k] - q[j].t - 1] = 1'b1;
        return sb;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic h;
            wr_t  w;
            if (rst) begin
                if (k == 0) q0.delete(); else q1.delete();
                st_m[k] = 0;
                fz_m[k] = 0;
            end else if (mem_busy) begin
                fz_m[k]++;
            end else begin
                h = model_hz(k);
                if (h) st_m[k]++;
                if (id_valid && !flush && !h && id_wb_en) begin
                    w.t = adv[k]; w.dest = id_dest; w.ld = id_mem_r_en;
                    if (k == 0) q0.push_back(w); else q1.push_back(w);
                end
                adv[k]++;
                if (k == 0) begin
                    while (q0.size() > 0 && adv[0] - q0[0].t - 1 >= stages[0]) void'(q0.pop_front());
                end else begin
                    while (q1.size() > 0 && adv[1] - q1[0].t - 1 >= stages[1]) void'(q1.pop_front());
                end
            end
        end
    end

    function automatic int exp_cnt(int v);
`ifdef HAZARD_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("hazard_a", hazard_a, model_hz(0));
            chk("hazard_b", hazard_b, model_hz(1));
            chk("sb_a", sb_a, model_sb(0) & 3'b011);
            chk("sb_b", sb_b, model_sb(1));
            chk("freeze_a", freeze_a, mem_busy);
            chk("freeze_b", freeze_b, mem_busy);
            chk("stall_a", stall_a, exp_cnt(st_m[0]));
            chk("stall_b", stall_b, exp_cnt(st_m[1]));
            chk("frz_a", frz_a, exp_cnt(fz_m[0]));
            chk("frz_b", frz_b, exp_cnt(fz_m[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic valid, input logic [3:0] s1, input logic u1,
                             input logic [3:0] s2, input logic u2, input logic wb,
                             input logic [3:0] d, input logic ld);
        id_valid = valid; id_src1 = s1; id_use_src1 = u1; id_src2 = s2; id_use_src2 = u2;
        id_wb_en = wb; id_dest = d; id_mem_r_en = ld;
    endtask

    task automatic bubble();
        set_instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        flush = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        bubble();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Hold the current ID instruction until neither instance stalls; count stall cycles.
    task automatic hold_count(output int na, output int nb, output logic [1:0] sb0, output logic [1:0] sb1);
        int n = 0;
        na = 0; nb = 0; sb0 = '0; sb1 = '0;
        forever begin
            @(negedge clk);
            if (hazard_a) begin
                if (na == 0) sb0 = sb_a;
                if (na == 1) sb1 = sb_a;
                na++;
            end
            if (hazard_b) nb++;
            if (!hazard_a && !hazard_b) break;
            n++;
            if (n > 20) begin
                chk("hold_timeout", 1, 0);
                break;
            end
            step();
        end
        step();
        bubble();
    endtask

    int          na, nb;
    logic [1:0]  sb0, sb1;

    initial begin
        // reset with a live-looking reader in ID
        rst = 1'b1;
        set_instr(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        step();
        step();
        @(negedge clk);
        chk("rst_sb_a", sb_a, 2'b00);
        chk("rst_hazard_a", hazard_a, 1'b0);
        chk("rst_stall_a", stall_a, 0);
        chk("rst_frz_a", frz_a, 0);
        chk_on = 1'b1;
        step();
        rst = 1'b0;
        bubble();

        // no forwarding: ADD r1 then SUB reading r1
        forward_en = 1'b0;
        do_reset();
        set_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        step();
        set_instr(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0);
        hold_count(na, nb, sb0, sb1);
        chk("nofwd_stalls_a", na, 2);
        chk("nofwd_stalls_b", nb, 3);
        chk("nofwd_sb_first", sb0, 2'b01);
        chk("nofwd_sb_second", sb1, 2'b10);
        @(negedge clk);
        chk("nofwd_stall_cnt", stall_a, exp_cnt(2));
        step();

        // forwarding: LDR r2 then ADD r2
        forward_en = 1'b1;
        do_reset();
        set_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1);
        step();
        set_instr(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0);
        hold_count(na, nb, sb0, sb1);
        chk("loaduse_stalls_a", na, 1);
        chk("loaduse_stalls_b", nb, 2);

        // forwarding: MOV r2 then ADD r2 (src2 side)
        do_reset();
        set_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
        step();
        set_instr(1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd6, 1'b0);
        hold_count(na, nb, sb0, sb1);
        chk("mov_stalls_a", na, 0);
        chk("mov_stalls_b", nb, 0);

        // load-use under a 3-cycle memory freeze
        do_reset();
        set_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1);
        step();
        set_instr(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy_hazard_a", hazard_a, 1'b1);
            chk("busy_sb_a", sb_a, 2'b01);
            step();
        end
        mem_busy = 1'b0;
        hold_count(na, nb, sb0, sb1);
        chk("busy_stalls_a", na, 1);
        chk("busy_stalls_b", nb, 2);
        @(negedge clk);
        chk("busy_frz_cnt", frz_a, exp_cnt(3));
        chk("busy_stall_cnt", stall_a, exp_cnt(1));
        step();

        // flushed dependent never stalls and inserts a bubble
        forward_en = 1'b0;
        do_reset();
        set_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        step();
        set_instr(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_hazard_a", hazard_a, 1'b0);
        step();
        bubble();
        @(negedge clk);
        chk("flush_sb_a", sb_a, 2'b10);
        step();

        // operands that are not read do not create a dependency
        do_reset();
        set_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        step();
        set_instr(1'b1, 4'd1, 1'b0, 4'd1, 1'b0, 1'b1, 4'd7, 1'b0);
        @(negedge clk);
        chk("nouse_hazard_a", hazard_a, 1'b0);
        chk("nouse_hazard_b", hazard_b, 1'b0);
        step();
        bubble();

        // randomized traffic, including mid-stream resets and forwarding toggles
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 99) < 2);
            forward_en  = ($urandom_range(0, 9) < 6);
            id_valid    = ($urandom_range(0, 9) < 8);
            id_src1     = 4'($urandom_range(0, 3));
            id_src2     = 4'($urandom_range(0, 3));
            id_use_src1 = ($urandom_range(0, 9) < 7);
            id_use_src2 = ($urandom_range(0, 9) < 5);
            id_wb_en    = ($urandom_range(0, 9) < 7);
            id_dest     = 4'($urandom_range(0, 3));
            id_mem_r_en = ($urandom_range(0, 9) < 4);
            flush       = ($urandom_range(0, 9) < 1);
            mem_busy    = ($urandom_range(0, 9) < 2);
            step();
        end
        rst = 1'b0;
        bubble();
        step();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
